// File: rtl/csr_trap_ctrl.sv
// Trap/interrupt controller: runs the machine-mode CSR write sequence for exceptions,
// interrupts and MRET, stalls the pipeline and redirects fetch.
module csr_trap_ctrl #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exp_req_i,
  input  logic [3:0]            exp_cause_i,
  input  logic [DATA_WIDTH-1:0] exp_tval_i,
  input  logic                  mret_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  ext_irq_i,
  input  logic                  sft_irq_i,
  input  logic                  tmr_irq_i,
  input  logic                  ex_csr_we_i,
  input  logic [DATA_WIDTH-1:0] csr_mstatus_i,
  input  logic [DATA_WIDTH-1:0] csr_mie_i,
  input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
  input  logic [DATA_WIDTH-1:0] csr_mepc_i,
  output logic                  clt_we_o,
  output logic [11:0]           clt_addr_o,
  output logic [DATA_WIDTH-1:0] clt_data_o,
  output logic                  hold_o,
  output logic                  jump_o,
  output logic [DATA_WIDTH-1:0] jump_addr_o
);

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;
  localparam logic [11:0] AddrMtval   = 12'h343;

  typedef enum logic [2:0] {
    StIdle, StWMepc, StWMcause, StWMtval, StWMstatus, StRMstatus, StJump
  } state_e;

  state_e                state_q;
  logic                  we_q;
  logic [11:0]           addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  hold_q;
  logic                  jump_q;
  logic [DATA_WIDTH-1:0] jump_addr_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] cause_q;
  logic [DATA_WIDTH-1:0] tval_q;
  logic [DATA_WIDTH-1:0] mepc_q;
  logic                  is_irq_q;

  logic                  ext_pend, sft_pend, tmr_pend, irq_ok;
  logic                  accept;
  logic [3:0]            irq_code;
  logic [DATA_WIDTH-1:0] cause_d;
  logic [DATA_WIDTH-1:0] mstatus_trap, mstatus_mret;
  logic [DATA_WIDTH-1:0] tvec_base, trap_target, mret_target;

  logic unused_mie;
  assign unused_mie = ^{csr_mie_i[DATA_WIDTH-1:12], csr_mie_i[10:8], csr_mie_i[6:4],
                        csr_mie_i[2:0], pc_q[0]};

  always_comb begin
    ext_pend = ext_irq_i & csr_mie_i[11];
    sft_pend = sft_irq_i & csr_mie_i[3];
    tmr_pend = tmr_irq_i & csr_mie_i[7];
    irq_ok   = csr_mstatus_i[3] & (ext_pend | sft_pend | tmr_pend);
    accept   = (state_q == StIdle) & ~ex_csr_we_i & (exp_req_i | mret_i | irq_ok);

    irq_code = ext_pend ? 4'd11 : (sft_pend ? 4'd3 : 4'd7);
    cause_d  = exp_req_i ? {{(DATA_WIDTH-4){1'b0}}, exp_cause_i}
                         : {1'b1, {(DATA_WIDTH-5){1'b0}}, irq_code};

    mstatus_trap        = csr_mstatus_i;
    mstatus_trap[7]     = csr_mstatus_i[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;

    mstatus_mret        = csr_mstatus_i;
    mstatus_mret[3]     = csr_mstatus_i[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;

    tvec_base   = {csr_mtvec_i[DATA_WIDTH-1:2], 2'b00};
    // Vectored mode only offsets interrupts; exceptions always land on the base.
    if (VECTORED_EN && (csr_mtvec_i[1:0] == 2'b01) && is_irq_q) begin
      trap_target = tvec_base + {{(DATA_WIDTH-6){1'b0}}, cause_q[3:0], 2'b00};
    end else begin
      trap_target = tvec_base;
    end
    mret_target = {mepc_q[DATA_WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      hold_q      <= 1'b0;
      jump_q      <= 1'b0;
      jump_addr_q <= '0;
      pc_q        <= '0;
      cause_q     <= '0;
      tval_q      <= '0;
      mepc_q      <= '0;
      is_irq_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            hold_q <= 1'b1;
            we_q   <= 1'b1;
            pc_q   <= pc_i;
            mepc_q <= csr_mepc_i;
            if (!exp_req_i && mret_i) begin
              state_q <= StRMstatus;
              addr_q  <= AddrMstatus;
              data_q  <= mstatus_mret;
            end else begin
              state_q  <= StWMepc;
              addr_q   <= AddrMepc;
              data_q   <= pc_i;
              cause_q  <= cause_d;
              tval_q   <= exp_req_i ? exp_tval_i : '0;
              is_irq_q <= ~exp_req_i;
            end
          end
        end
        StWMepc: begin
          if (!ex_csr_we_i) begin
            state_q <= StWMcause;
            addr_q  <= AddrMcause;
            data_q  <= cause_q;
          end
        end
        StWMcause: begin
          if (!ex_csr_we_i) begin
            state_q <= StWMtval;
            addr_q  <= AddrMtval;
            data_q  <= tval_q;
          end
        end
        StWMtval: begin
          if (!ex_csr_we_i) begin
            state_q <= StWMstatus;
            addr_q  <= AddrMstatus;
            data_q  <= mstatus_trap;
          end
        end
        StWMstatus, StRMstatus: begin
          if (!ex_csr_we_i) begin
            state_q     <= StJump;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            jump_q      <= 1'b1;
            jump_addr_q <= (state_q == StRMstatus) ? mret_target : trap_target;
          end
        end
        StJump: begin
          state_q     <= StIdle;
          jump_q      <= 1'b0;
          jump_addr_q <= '0;
          hold_q      <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign clt_we_o    = we_q;
  assign clt_addr_o  = addr_q;
  assign clt_data_o  = data_q;
  assign hold_o      = hold_q | accept;
  assign jump_o      = jump_q;
  assign jump_addr_o = jump_addr_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed scenarios plus random traffic against a
// transaction-level model that predicts the per-cycle CSR write / jump trace.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exp_req_i = 1'b0;
  logic [3:0]  exp_cause_i = '0;
  logic [63:0] exp_tval_i = '0;
  logic        mret_i = 1'b0;
  logic [63:0] pc_i = '0;
  logic        ext_irq_i = 1'b0, sft_irq_i = 1'b0, tmr_irq_i = 1'b0;
  logic        ex_csr_we_i = 1'b0;
  logic [63:0] csr_mstatus_i = '0, csr_mie_i = '0, csr_mtvec_i = '0, csr_mepc_i = '0;
  logic        clt_we_o;
  logic [11:0] clt_addr_o;
  logic [63:0] clt_data_o;
  logic        hold_o, jump_o;
  logic [63:0] jump_addr_o;

  csr_trap_ctrl #(.DATA_WIDTH(64), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .exp_req_i(exp_req_i), .exp_cause_i(exp_cause_i), .exp_tval_i(exp_tval_i),
    .mret_i(mret_i), .pc_i(pc_i),
    .ext_irq_i(ext_irq_i), .sft_irq_i(sft_irq_i), .tmr_irq_i(tmr_irq_i),
    .ex_csr_we_i(ex_csr_we_i),
    .csr_mstatus_i(csr_mstatus_i), .csr_mie_i(csr_mie_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .clt_we_o(clt_we_o), .clt_addr_o(clt_addr_o), .clt_data_o(clt_data_o),
    .hold_o(hold_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [63:0] data;
    logic        jump;
    logic [63:0] jaddr;
  } cyc_t;

  cyc_t        q[$];
  int          total = 0, bad = 0, cyc = 0;
  int          acc_cyc = 0, last_jump_cyc = 0, n_jumps = 0, saved_jumps;
  logic [63:0] last_jaddr = '0, last_ms_wr = '0, last_mcause = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [63:0] trap_ms(input logic [63:0] ms);
    return (ms & ~64'h1888) | 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
  endfunction

  function automatic logic [63:0] mret_ms(input logic [63:0] ms);
    return (ms & ~64'h1888) | 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
  endfunction

  task automatic push_trap(input logic [63:0] cause, input logic [63:0] tval, input logic irq);
    logic [63:0] base, tgt;
    base = csr_mtvec_i & ~64'h3;
    tgt  = (irq && csr_mtvec_i[1:0] == 2'b01) ? base + (64'(cause[3:0]) * 64'd4) : base;
    q.push_back('{1'b1, 12'h341, pc_i, 1'b0, 64'h0});
    q.push_back('{1'b1, 12'h342, cause, 1'b0, 64'h0});
    q.push_back('{1'b1, 12'h343, tval, 1'b0, 64'h0});
    q.push_back('{1'b1, 12'h300, trap_ms(csr_mstatus_i), 1'b0, 64'h0});
    q.push_back('{1'b0, 12'h0, 64'h0, 1'b1, tgt});
  endtask

  // Inputs are set by the caller at a negedge; this checks that cycle and advances one clock.
  task automatic step();
    cyc_t        e;
    logic        acc, want_hold;
    logic [2:0]  pend;
    logic [63:0] code;
    #1;
    acc = 1'b0;
    if (q.size() > 0) begin
      e = q[0];
      want_hold = 1'b1;
      if (!(e.we && ex_csr_we_i)) q.delete(0);
    end else begin
      e = '{1'b0, 12'h0, 64'h0, 1'b0, 64'h0};
      pend = {ext_irq_i & csr_mie_i[11], sft_irq_i & csr_mie_i[3], tmr_irq_i & csr_mie_i[7]};
      if (!ex_csr_we_i) begin
        if (exp_req_i) begin
          acc = 1'b1;
          push_trap({60'h0, exp_cause_i}, exp_tval_i, 1'b0);
        end else if (mret_i) begin
          acc = 1'b1;
          q.push_back('{1'b1, 12'h300, mret_ms(csr_mstatus_i), 1'b0, 64'h0});
          q.push_back('{1'b0, 12'h0, 64'h0, 1'b1, csr_mepc_i & ~64'h3});
        end else if (csr_mstatus_i[3] && pend != 3'b000) begin
          acc = 1'b1;
          code = pend[2] ? 64'd11 : (pend[1] ? 64'd3 : 64'd7);
          push_trap((64'h1 << 63) | code, 64'h0, 1'b1);
        end
      end
      want_hold = acc;
    end
    check_eq("we", 64'(clt_we_o), 64'(e.we));
    check_eq("addr", 64'(clt_addr_o), 64'(e.addr));
    check_eq("data", clt_data_o, e.data);
    check_eq("hold", 64'(hold_o), 64'(want_hold));
    check_eq("jump", 64'(jump_o), 64'(e.jump));
    check_eq("jaddr", jump_addr_o, e.jaddr);
    if (clt_we_o && clt_addr_o == 12'h300) last_ms_wr = clt_data_o;
    if (clt_we_o && clt_addr_o == 12'h342) last_mcause = clt_data_o;
    if (jump_o) begin
      last_jaddr = jump_addr_o;
      last_jump_cyc = cyc;
      n_jumps++;
    end
    if (acc) acc_cyc = cyc;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check_eq("rst_we", 64'(clt_we_o), 64'h0);
    check_eq("rst_hold", 64'(hold_o), 64'h0);
    check_eq("rst_jaddr", jump_addr_o, 64'h0);
    rst_n = 1'b1;

    // Exception with vectored mtvec: exceptions still go to base.
    csr_mstatus_i = 64'h8; csr_mtvec_i = 64'h80000101;
    exp_req_i = 1'b1; exp_cause_i = 4'd2; pc_i = 64'h80000010; exp_tval_i = 64'hdead;
    step();
    exp_req_i = 1'b0;
    repeat (5) step();
    check_eq("exc_ms", last_ms_wr, 64'h1880);
    check_eq("exc_jaddr", last_jaddr, 64'h80000100);
    check_eq("exc_lat", 64'(last_jump_cyc - acc_cyc), 64'd5);

    // Timer interrupt, vectored offset 4*7.
    csr_mie_i = 64'h80; tmr_irq_i = 1'b1;
    step();
    tmr_irq_i = 1'b0;
    repeat (5) step();
    check_eq("tmr_cause", last_mcause, 64'h8000000000000007);
    check_eq("tmr_jaddr", last_jaddr, 64'h8000011C);

    // Globally disabled: no acceptance.
    csr_mstatus_i = 64'h0; tmr_irq_i = 1'b1; saved_jumps = n_jumps;
    repeat (4) step();
    check_eq("mie_off_jumps", 64'(n_jumps), 64'(saved_jumps));
    tmr_irq_i = 1'b0;

    // Exception beats pending irqs; ext irq follows after return.
    csr_mstatus_i = 64'h8; csr_mie_i = 64'h888;
    ext_irq_i = 1'b1; sft_irq_i = 1'b1; tmr_irq_i = 1'b1;
    exp_req_i = 1'b1; exp_cause_i = 4'd5;
    step();
    exp_req_i = 1'b0;
    repeat (5) step();
    check_eq("prio_exc", last_mcause, 64'h5);
    repeat (6) step();
    check_eq("prio_ext", last_mcause, 64'h800000000000000B);
    ext_irq_i = 1'b0; sft_irq_i = 1'b0; tmr_irq_i = 1'b0;
    step();

    // MRET.
    csr_mstatus_i = 64'h1880; csr_mepc_i = 64'h80000013; mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    repeat (3) step();
    check_eq("mret_ms", last_ms_wr, 64'h1888);
    check_eq("mret_jaddr", last_jaddr, 64'h80000010);
    check_eq("mret_lat", 64'(last_jump_cyc - acc_cyc), 64'd2);

    // Two stall cycles during W_MCAUSE.
    csr_mstatus_i = 64'h8; exp_req_i = 1'b1; exp_cause_i = 4'd4;
    step();
    exp_req_i = 1'b0;
    step();
    ex_csr_we_i = 1'b1;
    repeat (2) step();
    ex_csr_we_i = 1'b0;
    repeat (5) step();
    check_eq("stall_lat", 64'(last_jump_cyc - acc_cyc), 64'd7);

    // Reset in the middle of W_MCAUSE.
    exp_req_i = 1'b1;
    step();
    exp_req_i = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_we", 64'(clt_we_o), 64'h0);
    check_eq("mid_rst_hold", 64'(hold_o), 64'h0);
    check_eq("mid_rst_jump", 64'(jump_o), 64'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    saved_jumps = n_jumps;
    repeat (6) step();
    check_eq("post_rst_jumps", 64'(n_jumps), 64'(saved_jumps));

    // Random traffic; CSR inputs only change while the unit is idle.
    repeat (3000) begin
      if (q.size() == 0) begin
        csr_mstatus_i = {$urandom, $urandom};
        csr_mie_i     = {$urandom, $urandom};
        csr_mtvec_i   = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) csr_mtvec_i[63:8] = '1;
        if ($urandom_range(0, 1) == 0) csr_mtvec_i[1:0] = 2'b01;
        csr_mepc_i    = {$urandom, $urandom};
      end
      exp_req_i   = ($urandom_range(0, 7) == 0);
      exp_cause_i = 4'($urandom);
      exp_tval_i  = {$urandom, $urandom};
      pc_i        = {$urandom, $urandom};
      mret_i      = ($urandom_range(0, 7) == 0);
      ext_irq_i   = ($urandom_range(0, 3) == 0);
      sft_irq_i   = ($urandom_range(0, 3) == 0);
      tmr_irq_i   = ($urandom_range(0, 3) == 0);
      ex_csr_we_i = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
